// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared definitions for the parameterised UART core:         |
// |               parity-mode constants, TX/RX FSM state types and the        |
// |               parity-bit helper used by both directions.                  |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // TX_WAIT holds an accepted byte until the next oversample tick.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_WAIT   = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity bit over the data bits only. Callers zero-extend narrower data
  // to 9 bits; the extra zeros do not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input int par);
    logic x;
    x = ^data;
    return (par == PAR_ODD) ? ~x : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_param_core_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_baud_tick                                               |
// | Description : Reload down-counter producing a 1-clk oversample tick every  |
// |               i_baud_div+1 clock cycles. i_baud_div is sampled only on     |
// |               reload. The tick is a clock enable, not a clock.             |
// | Ports       : clk, reset (sync, active high), i_baud_div [DIV_W], o_tick   |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] i_baud_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_reload;

  // Counter at zero is the tick cycle; reset leaves it at zero so the first
  // tick appears right after reset.
  assign w_reload = (r_cnt == '0);
  assign o_tick   = w_reload;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_reload) begin
      r_cnt <= i_baud_div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_param_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_param_core                                              |
// | Description : Single-clock UART transceiver, runtime baud divisor,        |
// |               compile-time frame format (DATA_BITS 5..9, PARITY            |
// |               none/odd/even, STOP_BITS 1/2, OVER 8/16 oversampling).       |
// | Ports       : clk, reset (sync, active high), baud_div, tx_data, tx_valid, |
// |               tx_ready, txd, rxd, rx_data, rx_valid, rx_ready,             |
// |               parity_error, stop_error, overrun                            |
// |               [loopback when UART_LOOPBACK_EN is defined]                  |
// | Config      : UART_LOOPBACK_EN - adds loopback input; RX fed from the      |
// |               internal TX bit and txd held high while loopback=1.          |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module uart_param_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVER      = 16,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 overrun
);

  localparam int          PH_W      = $clog2(OVER);
  localparam int          BIT_W     = 4;
  localparam logic [PH_W-1:0] c_PH_LAST = PH_W'(OVER - 1);
  localparam logic [PH_W-1:0] c_PH_HALF = PH_W'(OVER / 2 - 1);
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic        c_STOP_LAST = 1'(STOP_BITS - 1);

  logic w_tick;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk        (clk),
    .reset      (reset),
    .i_baud_div (baud_div),
    .o_tick     (w_tick)
  );

  // ---------------------------------------------------------------- TX ----
  tx_state_t            r_tx_state;
  logic [PH_W-1:0]      r_tx_phase;
  logic [BIT_W-1:0]     r_tx_bit;
  logic                 r_tx_stop;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_txd;
  logic                 r_tx_ready;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = w_tick && (r_tx_phase == c_PH_LAST);
  assign tx_ready     = r_tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_phase <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      // Phase advances on every tick while a bit is on the line.
      if (w_tick && (r_tx_state != TX_IDLE) && (r_tx_state != TX_WAIT)) begin
        r_tx_phase <= w_tx_bit_end ? '0 : r_tx_phase + 1'b1;
      end
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_valid && r_tx_ready) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= calc_parity(9'(tx_data), PARITY);
            r_tx_ready <= 1'b0;
            r_tx_phase <= '0;
            // A tick in the acceptance cycle starts the frame immediately.
            if (w_tick) begin
              r_txd      <= 1'b0;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_WAIT;
            end
          end
        end
        TX_WAIT: begin
          if (w_tick) begin
            r_txd      <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            if (r_tx_bit == c_BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                r_txd      <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_txd      <= 1'b1;
                r_tx_stop  <= 1'b0;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (w_tx_bit_end) begin
            r_txd      <= 1'b1;
            r_tx_stop  <= 1'b0;
            r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            if (r_tx_stop == c_STOP_LAST) begin
              r_tx_ready <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_stop <= 1'b1;
            end
          end
        end
        default: begin
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------ line routing ----
  logic w_rx_in;

`ifdef UART_LOOPBACK_EN
  assign w_rx_in = loopback ? r_txd : rxd;
  assign txd     = loopback ? 1'b1 : r_txd;
`else
  assign w_rx_in = rxd;
  assign txd     = r_txd;
`endif

  // ---------------------------------------------------------------- RX ----
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  logic                 w_rx_fall;
  rx_state_t            r_rx_state;
  logic [PH_W-1:0]      r_rx_phase;
  logic [BIT_W-1:0]     r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_perr;
  logic                 r_serr;
  logic                 r_ovr;
  logic                 w_rx_bit_end;

  assign w_rx_fall    = r_rx_prev && !r_sync2;
  assign w_rx_bit_end = w_tick && (r_rx_phase == c_PH_LAST);

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign parity_error = r_perr;
  assign stop_error   = r_serr;
  assign overrun      = r_ovr;

  // Synchroniser flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= w_rx_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_phase <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      // Consumption; a completion below in the same cycle takes priority.
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_tick && (r_rx_state != RX_IDLE)) begin
        r_rx_phase <= (r_rx_phase == c_PH_LAST) ? '0 : r_rx_phase + 1'b1;
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_phase <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start check; from here on phase wraps at mid-bit.
          if (w_tick && (r_rx_phase == c_PH_HALF)) begin
            r_rx_phase <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == c_BIT_LAST) begin
              r_rx_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (w_rx_bit_end) begin
            r_rx_par   <= r_sync2;
            r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Completion on the first stop-bit sample; errored frames are
          // still presented.
          if (w_rx_bit_end) begin
            r_rx_data  <= r_rx_shift;
            r_perr     <= (PARITY != PAR_NONE) &&
                          (calc_parity(9'(r_rx_shift), PARITY) != r_rx_par);
            r_serr     <= !r_sync2;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !rx_ready) begin
              r_ovr <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_param_core.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_param_core                                           |
// | Description : Self-checking bench. Three cores share clk/reset/baud_div:  |
// |               inst 0 = 8N1 (rxd driven by bench), inst 1 = 8E1 (rxd tied   |
// |               to its own txd), inst 2 = 8O1 (rxd driven by bench).         |
// |               Expected line bits and RX results come from a frame model.   |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_uart_param_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd0;

  logic [7:0]  tx_data  [3];
  logic        tx_valid [3];
  logic        rx_ready [3];
  logic        rxd_drv  [3];

  wire         tx_ready_w [3];
  wire         txd_w      [3];
  wire  [7:0]  rx_data_w  [3];
  wire         rx_valid_w [3];
  wire         perr_w     [3];
  wire         serr_w     [3];
  wire         ovr_w      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_param_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVER(16), .DIV_W(16)) u_n (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .baud_div(baud_div), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready_w[0]), .txd(txd_w[0]), .rxd(rxd_drv[0]),
    .rx_data(rx_data_w[0]), .rx_valid(rx_valid_w[0]), .rx_ready(rx_ready[0]),
    .parity_error(perr_w[0]), .stop_error(serr_w[0]), .overrun(ovr_w[0]));

  uart_param_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVER(16), .DIV_W(16)) u_e (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .baud_div(baud_div), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready_w[1]), .txd(txd_w[1]), .rxd(txd_w[1]),
    .rx_data(rx_data_w[1]), .rx_valid(rx_valid_w[1]), .rx_ready(rx_ready[1]),
    .parity_error(perr_w[1]), .stop_error(serr_w[1]), .overrun(ovr_w[1]));

  uart_param_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVER(16), .DIV_W(16)) u_o (
    .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .baud_div(baud_div), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready_w[2]), .txd(txd_w[2]), .rxd(rxd_drv[2]),
    .rx_data(rx_data_w[2]), .rx_valid(rx_valid_w[2]), .rx_ready(rx_ready[2]),
    .parity_error(perr_w[2]), .stop_error(serr_w[2]), .overrun(ovr_w[2]));

  // ------------------------------------------------------------ model ----
  // Parity mode per instance: 0 none, 1 odd, 2 even.
  function automatic int ptype_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic bit model_par(input logic [7:0] d, input int pt);
    int ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(d[k]);
    if (pt == 2) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  // Line bits of one frame (start, data LSB first, [parity], stop).
  function automatic int build_frame(input logic [7:0] d, input int pt, input bit flip,
                                     input bit stop0, output bit b[12]);
    int n;
    b = '{default: 1'b1};
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[1+k] = d[k];
    n = 9;
    if (pt != 0) begin
      b[9] = model_par(d, pt) ^ flip;
      n = 10;
    end
    b[n] = !stop0;
    return n + 1;
  endfunction

  // ------------------------------------------------------------ tasks ----
  task automatic tx_frame_body(input int i, input logic [7:0] d, output bit cap[12]);
    bit b[12];
    int n, bad, low;
    logic seen;
    n = build_frame(d, ptype_of(i), 1'b0, 1'b0, b);
    cap = '{default: 1'b1};
    low = 0;
    seen = 1'b0;
    for (int j = 0; j < n; j++) begin
      bad = 0;
      for (int s = 0; s < 16; s++) begin
        if (s == 8) cap[j] = txd_w[i];
        if (txd_w[i] !== b[j]) begin bad++; seen = txd_w[i]; end
        if (tx_ready_w[i] === 1'b0) low++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL tx_bit inst %0d bit %0d: %0d of 16 samples were %b, expected %b",
                 i, j, bad, seen, b[j]);
      end
    end
    checks++;
    if (low != 16 * n) begin
      errors++;
      $display("FAIL tx_ready_low inst %0d: low for %0d clk, expected %0d", i, low, 16 * n);
    end
    checks++;
    if (tx_ready_w[i] !== 1'b1 || txd_w[i] !== 1'b1) begin
      errors++;
      $display("FAIL tx_end inst %0d: tx_ready=%b txd=%b, expected 1 1", i, tx_ready_w[i], txd_w[i]);
    end
  endtask

  task automatic tx_send_check(input int i, input logic [7:0] d, output bit cap[12]);
    int w = 0;
    cap = '{default: 1'b1};
    while (tx_ready_w[i] !== 1'b1 && w < 400) begin @(negedge clk); w++; end
    if (w >= 400) begin
      checks++; errors++;
      $display("FAIL tx_ready_wait inst %0d: tx_ready=%b after 400 clk, expected 1", i, tx_ready_w[i]);
      return;
    end
    tx_valid[i] = 1'b1;
    tx_data[i]  = d;
    @(negedge clk);
    tx_valid[i] = 1'b0;
    tx_frame_body(i, d, cap);
  endtask

  task automatic rx_drive(input int i, input logic [7:0] d, input bit flip, input bit stop0);
    bit b[12];
    int n;
    n = build_frame(d, ptype_of(i), flip, stop0, b);
    for (int j = 0; j < n; j++) begin
      rxd_drv[i] = b[j];
      repeat (16) @(negedge clk);
    end
    rxd_drv[i] = 1'b1;
  endtask

  task automatic rx_check(input int i, input logic [7:0] d, input bit pe, input bit se);
    checks++;
    if (rx_valid_w[i] !== 1'b1) begin
      errors++; $display("FAIL rx_valid inst %0d: got %b, expected 1", i, rx_valid_w[i]);
    end
    checks++;
    if (rx_data_w[i] !== d) begin
      errors++; $display("FAIL rx_data inst %0d: got %h, expected %h", i, rx_data_w[i], d);
    end
    checks++;
    if (perr_w[i] !== pe) begin
      errors++; $display("FAIL parity_error inst %0d: got %b, expected %b", i, perr_w[i], pe);
    end
    checks++;
    if (serr_w[i] !== se) begin
      errors++; $display("FAIL stop_error inst %0d: got %b, expected %b", i, serr_w[i], se);
    end
  endtask

  task automatic rx_consume(input int i);
    rx_ready[i] = 1'b1;
    @(negedge clk);
    rx_ready[i] = 1'b0;
    checks++;
    if (rx_valid_w[i] !== 1'b0) begin
      errors++; $display("FAIL rx_consume inst %0d: rx_valid=%b, expected 0", i, rx_valid_w[i]);
    end
  endtask

  // ------------------------------------------------------------ tests ----
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (txd_w[i] !== 1'b1 || tx_ready_w[i] !== 1'b1 || rx_valid_w[i] !== 1'b0 ||
          rx_data_w[i] !== 8'h00 || perr_w[i] !== 1'b0 || serr_w[i] !== 1'b0 || ovr_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst %0d: txd=%b rdy=%b rxv=%b rxd=%h pe=%b se=%b ov=%b, expected 1 1 0 00 0 0 0",
                 i, txd_w[i], tx_ready_w[i], rx_valid_w[i], rx_data_w[i], perr_w[i], serr_w[i], ovr_w[i]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_8n1();
    bit cap[12];
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'hA5;
    @(negedge clk);
    tx_data[0]  = 8'h5A;   // tx_valid stays high; next byte waits for tx_ready
    tx_frame_body(0, 8'hA5, cap);
    @(negedge clk);
    checks++;
    if (tx_ready_w[0] !== 1'b0 || txd_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL tx_reaccept: tx_ready=%b txd=%b, expected 0 0", tx_ready_w[0], txd_w[0]);
    end
    tx_valid[0] = 1'b0;
    tx_frame_body(0, 8'h5A, cap);
  endtask

  task automatic test_loop_8e1();
    bit cap[12];
    tx_send_check(1, 8'h3C, cap);
    checks++;
    if (cap[9] !== 1'b0) begin
      errors++; $display("FAIL even_parity_bit: line had %b, expected 0", cap[9]);
    end
    rx_check(1, 8'h3C, 1'b0, 1'b0);
    rx_consume(1);
  endtask

  task automatic test_rx_errors();
    rx_drive(2, 8'h3C, 1'b1, 1'b0);
    rx_check(2, 8'h3C, 1'b1, 1'b0);
    rx_consume(2);
    repeat (4) @(negedge clk);
    rx_drive(2, 8'h3C, 1'b0, 1'b1);
    rx_check(2, 8'h3C, 1'b0, 1'b1);
    rx_consume(2);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_false_start();
    int seen = 0;
    rxd_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv[0] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (rx_valid_w[0] === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL false_start: rx_valid high %0d clk, expected 0", seen);
    end
    rx_drive(0, 8'h11, 1'b0, 1'b0);
    rx_check(0, 8'h11, 1'b0, 1'b0);
    rx_consume(0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overrun();
    rx_drive(0, 8'h01, 1'b0, 1'b0);
    rx_check(0, 8'h01, 1'b0, 1'b0);
    checks++;
    if (ovr_w[0] !== 1'b0) begin
      errors++; $display("FAIL overrun_first: got %b, expected 0", ovr_w[0]);
    end
    rx_drive(0, 8'h02, 1'b0, 1'b0);
    rx_check(0, 8'h02, 1'b0, 1'b0);
    checks++;
    if (ovr_w[0] !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b, expected 1", ovr_w[0]);
    end
    rx_consume(0);
    checks++;
    if (ovr_w[0] !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b, expected 1", ovr_w[0]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit b[12];
    bit cap[12];
    int n;
    n = build_frame(8'h0F, 0, 1'b0, 1'b0, b);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'hF0;
    for (int t = 0; t < 60; t++) begin
      rxd_drv[0] = b[t / 16];
      @(negedge clk);
      tx_valid[0] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (txd_w[0] !== 1'b1 || tx_ready_w[0] !== 1'b1 || rx_valid_w[0] !== 1'b0 || ovr_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: txd=%b tx_ready=%b rx_valid=%b overrun=%b, expected 1 1 0 0",
               txd_w[0], tx_ready_w[0], rx_valid_w[0], ovr_w[0]);
    end
    reset = 1'b0;
    rxd_drv[0] = 1'b1;
    repeat (4) @(negedge clk);
    tx_send_check(0, 8'h55, cap);
    rx_drive(0, 8'h55, 1'b0, 1'b0);
    rx_check(0, 8'h55, 1'b0, 1'b0);
    rx_consume(0);
  endtask

  task automatic test_random();
    bit cap[12];
    logic [7:0] d;
    bit flip, s0;
    for (int it = 0; it < 6; it++) begin
      d = 8'($urandom);
      tx_send_check(1, d, cap);
      rx_check(1, d, 1'b0, 1'b0);
      rx_consume(1);
      d    = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      s0   = 1'($urandom_range(0, 1));
      rx_drive(2, d, flip, s0);
      rx_check(2, d, flip, s0);
      rx_consume(2);
      repeat (4) @(negedge clk);
      d = 8'($urandom);
      tx_send_check(0, d, cap);
    end
  endtask

  // ------------------------------------------------------------ main -----
  initial begin
    for (int i = 0; i < 3; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
      rx_ready[i] = 1'b0;
      rxd_drv[i]  = 1'b1;
    end
    test_reset();
    test_tx_8n1();
    test_loop_8e1();
    test_rx_errors();
    test_false_start();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
